// File: rtl/input_p4_demux_pkg.sv
// Shared types and constants for the input P4 demultiplexer.
package input_p4_demux_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFwd  = 2'd1,
        StDrop = 2'd2
    } state_e;

    localparam int unsigned MAC_LO       = 0;
    localparam int unsigned VLAN_TPID_LO = 96;
    // 0x8100 as it appears little-endian on the bus
    localparam logic [15:0] VLAN_TPID    = 16'h0081;

    localparam int unsigned SEL_MAC  = 0;
    localparam int unsigned SEL_VLAN = 1;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_p4_classifier.sv
// First-beat key extraction (dst MAC or VLAN ID) and lowest-index priority match.
module input_p4_classifier
    import input_p4_demux_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH = 256,
    parameter int unsigned NUM_VS            = 4,
    parameter int unsigned SEL_MODE          = SEL_MAC,
    parameter int unsigned KEY_W             = 48,
    localparam int unsigned IDX_W            = idx_width(NUM_VS)
) (
    input  logic [C_AXIS_DATA_WIDTH-1:0] tdata,
    input  logic [NUM_VS*KEY_W-1:0]      match_table,
    input  logic [NUM_VS-1:0]            chan_enable,
    output logic                         hit,
    output logic [IDX_W-1:0]             idx
);

    logic [NUM_VS-1:0] match;
    logic              unused_bits;

    // Only a subset of the beat and table bits feed the compare in either mode
    assign unused_bits = ^{tdata, match_table};

    for (genvar k = 0; k < NUM_VS; k++) begin : g_match
        logic key_eq;
        if (SEL_MODE == SEL_VLAN) begin : g_vlan
            assign key_eq = (tdata[VLAN_TPID_LO +: 16] == VLAN_TPID) &&
                            (match_table[k*KEY_W +: 12] == {tdata[115:112], tdata[127:120]});
        end else begin : g_mac
            assign key_eq = (match_table[k*KEY_W +: KEY_W] == KEY_W'(tdata[MAC_LO +: 48]));
        end
        assign match[k] = chan_enable[k] && key_eq;
    end

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_VS - 1; k >= 0; k--) begin
            if (match[k]) begin
                hit = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/input_p4_demux.sv
// AXI4-Stream 1-to-NUM_VS packet demux: classify on first beat, stream packet to the
// selected virtual switch through a single output register, drop and count misses.
module input_p4_demux
    import input_p4_demux_pkg::*;
#(
    parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned NUM_VS             = 4,
    parameter int unsigned SEL_MODE           = SEL_MAC,
    parameter int unsigned KEY_W              = 48
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,

    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,

    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tlast,
    output logic [NUM_VS-1:0]               m_axis_tvalid,
    input  logic [NUM_VS-1:0]               m_axis_tready,

    input  logic [NUM_VS*KEY_W-1:0]         match_table,
    input  logic [NUM_VS-1:0]               chan_enable,
    output logic [31:0]                     drop_cnt,
    output logic [NUM_VS*32-1:0]            fwd_cnt
);

    localparam int unsigned KEEP_W = C_AXIS_DATA_WIDTH / 8;
    localparam int unsigned IDX_W  = idx_width(NUM_VS);

    state_e                        state_q, state_d;
    logic [IDX_W-1:0]              sel_q, sel_d;
    logic                          rdy_en_q;

    logic [C_AXIS_DATA_WIDTH-1:0]  out_data_q;
    logic [KEEP_W-1:0]             out_keep_q;
    logic [C_AXIS_TUSER_WIDTH-1:0] out_user_q;
    logic                          out_last_q;
    logic                          out_valid_q;

    logic [31:0]                   drop_cnt_q;
    logic [31:0]                   fwd_cnt_q [NUM_VS];

    logic                          cls_hit;
    logic [IDX_W-1:0]              cls_idx;
    logic                          out_ready;
    logic                          drain;
    logic                          accept;
    logic                          load;
    logic                          drop_inc;

    input_p4_classifier #(
        .C_AXIS_DATA_WIDTH (C_AXIS_DATA_WIDTH),
        .NUM_VS            (NUM_VS),
        .SEL_MODE          (SEL_MODE),
        .KEY_W             (KEY_W)
    ) u_classifier (
        .tdata       (s_axis_tdata),
        .match_table (match_table),
        .chan_enable (chan_enable),
        .hit         (cls_hit),
        .idx         (cls_idx)
    );

    assign out_ready = m_axis_tready[sel_q];
    assign drain     = out_valid_q && out_ready;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        load          = 1'b0;
        drop_inc      = 1'b0;
        s_axis_tready = 1'b0;
        // rdy_en_q holds ready low in reset and until the first clock after release
        if (rdy_en_q) begin
            s_axis_tready = (state_q == StDrop) || !out_valid_q || out_ready;
        end
        accept = s_axis_tvalid && s_axis_tready;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (cls_hit) begin
                        load  = 1'b1;
                        sel_d = cls_idx;
                        if (!s_axis_tlast) state_d = StFwd;
                    end else if (s_axis_tlast) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StFwd: begin
                if (accept) begin
                    load = 1'b1;
                    if (s_axis_tlast) state_d = StIdle;
                end
            end
            StDrop: begin
                if (accept && s_axis_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_user_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_data_q  <= s_axis_tdata;
            out_keep_q  <= s_axis_tkeep;
            out_user_q  <= s_axis_tuser;
            out_last_q  <= s_axis_tlast;
            out_valid_q <= 1'b1;
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            drop_cnt_q <= '0;
        end else if (drop_inc && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            for (int k = 0; k < NUM_VS; k++) fwd_cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_VS; k++) begin
                if (drain && out_last_q && (sel_q == IDX_W'(k))) begin
                    fwd_cnt_q[k] <= fwd_cnt_q[k] + 32'd1;
                end
            end
        end
    end

    assign m_axis_tdata = out_data_q;
    assign m_axis_tkeep = out_keep_q;
    assign m_axis_tuser = out_user_q;
    assign m_axis_tlast = out_last_q;
    assign drop_cnt     = drop_cnt_q;

    for (genvar k = 0; k < NUM_VS; k++) begin : g_out
        assign m_axis_tvalid[k]       = out_valid_q && (sel_q == IDX_W'(k));
        assign fwd_cnt[k*32 +: 32]    = fwd_cnt_q[k];
    end

endmodule

// File: tb/tb_input_p4_demux.sv
// Directed bench: MAC-mode and VLAN-mode instances driven on a fixed cycle timeline.
module tb_input_p4_demux;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int NV = 4;
    localparam int KW = 48;
    localparam int KEEPW = DW / 8;

    typedef logic [255:0] w_t;

    localparam logic [47:0] MAC0 = 48'h110100000008;
    localparam logic [47:0] MAC1 = 48'h220200000008;
    localparam logic [47:0] MAC2 = 48'h330300000008;
    localparam logic [47:0] MAC3 = 48'h440400000008;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // MAC-mode instance
    logic [DW-1:0]    s_tdata;
    logic [KEEPW-1:0] s_tkeep;
    logic [UW-1:0]    s_tuser;
    logic             s_tvalid, s_tlast, s_tready;
    logic [DW-1:0]    m_tdata;
    logic [KEEPW-1:0] m_tkeep;
    logic [UW-1:0]    m_tuser;
    logic             m_tlast;
    logic [NV-1:0]    m_tvalid, m_tready;
    logic [NV*KW-1:0] tbl;
    logic [NV-1:0]    en;
    logic [31:0]      drop;
    logic [NV*32-1:0] fwd;

    // VLAN-mode instance
    logic [DW-1:0]    v_tdata;
    logic             v_tvalid, v_tlast, v_tready;
    logic [DW-1:0]    vm_tdata;
    logic [KEEPW-1:0] vm_tkeep;
    logic [UW-1:0]    vm_tuser;
    logic             vm_tlast;
    logic [NV-1:0]    vm_tvalid;
    logic [NV*KW-1:0] v_tbl;
    logic [NV-1:0]    v_en;
    logic [31:0]      v_drop;
    logic [NV*32-1:0] v_fwd;

    int n_cmp = 0;
    int n_err = 0;

    input_p4_demux #(
        .C_AXIS_DATA_WIDTH (DW), .C_AXIS_TUSER_WIDTH (UW), .NUM_VS (NV), .SEL_MODE (0),
        .KEY_W (KW)
    ) dut_mac (
        .axis_aclk (clk), .axis_resetn (resetn),
        .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
        .s_axis_tvalid (s_tvalid), .s_axis_tlast (s_tlast), .s_axis_tready (s_tready),
        .m_axis_tdata (m_tdata), .m_axis_tkeep (m_tkeep), .m_axis_tuser (m_tuser),
        .m_axis_tlast (m_tlast), .m_axis_tvalid (m_tvalid), .m_axis_tready (m_tready),
        .match_table (tbl), .chan_enable (en), .drop_cnt (drop), .fwd_cnt (fwd)
    );

    input_p4_demux #(
        .C_AXIS_DATA_WIDTH (DW), .C_AXIS_TUSER_WIDTH (UW), .NUM_VS (NV), .SEL_MODE (1),
        .KEY_W (KW)
    ) dut_vlan (
        .axis_aclk (clk), .axis_resetn (resetn),
        .s_axis_tdata (v_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tuser (s_tuser),
        .s_axis_tvalid (v_tvalid), .s_axis_tlast (v_tlast), .s_axis_tready (v_tready),
        .m_axis_tdata (vm_tdata), .m_axis_tkeep (vm_tkeep), .m_axis_tuser (vm_tuser),
        .m_axis_tlast (vm_tlast), .m_axis_tvalid (vm_tvalid), .m_axis_tready (m_tready),
        .match_table (v_tbl), .chan_enable (v_en), .drop_cnt (v_drop), .fwd_cnt (v_fwd)
    );

    task automatic check(input string tag, input w_t obs, input w_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic w_t beat(input logic [47:0] mac, input logic [7:0] tag);
        w_t d;
        d = '0;
        d[47:0]    = mac;
        d[255:248] = tag;
        d[150:143] = ~tag;
        return d;
    endfunction

    function automatic w_t vframe(input logic [15:0] tpid, input logic [11:0] vid,
                                  input logic [7:0] tag);
        w_t d;
        d = '0;
        d[47:0]    = 48'h0A0B0C0D0E0F;
        d[111:96]  = tpid;
        d[119:112] = {4'hA, vid[11:8]};
        d[127:120] = vid[7:0];
        d[255:248] = tag;
        return d;
    endfunction

    initial begin
        resetn   = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '1;
        s_tuser  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        v_tdata  = '0;
        v_tvalid = 1'b0;
        v_tlast  = 1'b0;
        m_tready = '1;
        tbl      = {MAC3, MAC2, MAC1, MAC0};
        en       = '1;
        v_tbl    = {48'h30C, 48'h00B, 48'h005, 48'h00A};
        v_en     = '1;

        // Reset state
        #1;
        check("rst_tvalid", w_t'(m_tvalid), w_t'(4'b0000));
        check("rst_tready", w_t'(s_tready), w_t'(1'b0));
        check("rst_drop", w_t'(drop), w_t'(32'd0));
        check("rst_fwd", w_t'(fwd), w_t'(128'd0));
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("rel_tready_before_clk", w_t'(s_tready), w_t'(1'b0));
        @(negedge clk);
        check("rel_tready_after_clk", w_t'(s_tready), w_t'(1'b1));

        // 1: 3-beat packet to ch2
        s_tvalid = 1'b1; s_tlast = 1'b0; s_tdata = beat(MAC2, 8'h11); s_tuser = 128'hA1;
        @(negedge clk);
        check("t1_v0", w_t'(m_tvalid), w_t'(4'b0100));
        check("t1_d0", m_tdata, beat(MAC2, 8'h11));
        check("t1_u0", w_t'(m_tuser), w_t'(128'hA1));
        check("t1_l0", w_t'(m_tlast), w_t'(1'b0));
        s_tdata = beat(MAC2, 8'h12); s_tuser = 128'hA2;
        @(negedge clk);
        check("t1_v1", w_t'(m_tvalid), w_t'(4'b0100));
        check("t1_d1", m_tdata, beat(MAC2, 8'h12));
        s_tdata = beat(MAC2, 8'h13); s_tuser = 128'hA3; s_tlast = 1'b1; s_tkeep = 32'h0000_00FF;
        @(negedge clk);
        check("t1_v2", w_t'(m_tvalid), w_t'(4'b0100));
        check("t1_d2", m_tdata, beat(MAC2, 8'h13));
        check("t1_l2", w_t'(m_tlast), w_t'(1'b1));
        check("t1_k2", w_t'(m_tkeep), w_t'(32'h0000_00FF));
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '1;
        @(negedge clk);
        check("t1_idle", w_t'(m_tvalid), w_t'(4'b0000));
        check("t1_fwd2", w_t'(fwd[2*32 +: 32]), w_t'(32'd1));

        // 2: back-to-back single-beat packets to ch0 then ch3
        s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = beat(MAC0, 8'h21);
        @(negedge clk);
        check("t2_v0", w_t'(m_tvalid), w_t'(4'b0001));
        check("t2_rdy0", w_t'(s_tready), w_t'(1'b1));
        s_tdata = beat(MAC3, 8'h22);
        @(negedge clk);
        check("t2_v1", w_t'(m_tvalid), w_t'(4'b1000));
        check("t2_d1", m_tdata, beat(MAC3, 8'h22));
        check("t2_rdy1", w_t'(s_tready), w_t'(1'b1));
        s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge clk);
        check("t2_fwd0", w_t'(fwd[0 +: 32]), w_t'(32'd1));
        check("t2_fwd3", w_t'(fwd[3*32 +: 32]), w_t'(32'd1));

        // 3: unknown MAC, 5 beats, dropped; then a matched packet
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1; s_tlast = (i == 4); s_tdata = beat(48'hDEADBEEF0000, 8'(i));
            #1;
            check("t3_rdy", w_t'(s_tready), w_t'(1'b1));
            @(negedge clk);
            check("t3_no_valid", w_t'(m_tvalid), w_t'(4'b0000));
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        check("t3_drop", w_t'(drop), w_t'(32'd1));
        s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = beat(MAC1, 8'h31);
        @(negedge clk);
        check("t3_after_v", w_t'(m_tvalid), w_t'(4'b0010));
        check("t3_after_d", m_tdata, beat(MAC1, 8'h31));
        s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge clk);
        check("t3_fwd1", w_t'(fwd[1*32 +: 32]), w_t'(32'd1));

        // 4: ch1 ready low for 4 cycles mid-packet
        s_tvalid = 1'b1; s_tdata = beat(MAC1, 8'h40);
        @(negedge clk);
        check("t4_v0", w_t'(m_tvalid), w_t'(4'b0010));
        s_tdata = beat(MAC1, 8'h41);
        m_tready = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t4_stall_rdy", w_t'(s_tready), w_t'(1'b0));
            @(negedge clk);
            check("t4_hold_d", m_tdata, beat(MAC1, 8'h40));
            check("t4_hold_v", w_t'(m_tvalid), w_t'(4'b0010));
        end
        m_tready = 4'b1111;
        #1;
        check("t4_resume_rdy", w_t'(s_tready), w_t'(1'b1));
        @(negedge clk);
        check("t4_d1", m_tdata, beat(MAC1, 8'h41));
        s_tdata = beat(MAC1, 8'h42); s_tlast = 1'b1;
        @(negedge clk);
        check("t4_d2", m_tdata, beat(MAC1, 8'h42));
        check("t4_l2", w_t'(m_tlast), w_t'(1'b1));
        s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge clk);
        check("t4_fwd1", w_t'(fwd[1*32 +: 32]), w_t'(32'd2));
        check("t4_idle", w_t'(m_tvalid), w_t'(4'b0000));

        // 6: asynchronous reset mid-packet
        s_tvalid = 1'b1; s_tdata = beat(MAC2, 8'h61);
        @(negedge clk);
        check("t6_v0", w_t'(m_tvalid), w_t'(4'b0100));
        s_tdata = beat(MAC2, 8'h62);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_v", w_t'(m_tvalid), w_t'(4'b0000));
        check("t6_rst_d", m_tdata, w_t'(0));
        check("t6_rst_rdy", w_t'(s_tready), w_t'(1'b0));
        check("t6_rst_fwd", w_t'(fwd), w_t'(128'd0));
        s_tvalid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("t6_rel_rdy0", w_t'(s_tready), w_t'(1'b0));
        @(negedge clk);
        check("t6_rel_rdy1", w_t'(s_tready), w_t'(1'b1));
        s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = beat(MAC3, 8'h71);
        @(negedge clk);
        check("t6_new_v", w_t'(m_tvalid), w_t'(4'b1000));
        check("t6_new_d", m_tdata, beat(MAC3, 8'h71));
        s_tvalid = 1'b0; s_tlast = 1'b0;
        @(negedge clk);
        check("t6_fwd3", w_t'(fwd[3*32 +: 32]), w_t'(32'd1));
        check("t6_fwd2", w_t'(fwd[2*32 +: 32]), w_t'(32'd0));
        check("t6_drop", w_t'(drop), w_t'(32'd0));

        // 5: VLAN mode
        v_tvalid = 1'b1; v_tlast = 1'b1; v_tdata = vframe(16'h0081, 12'h005, 8'h51);
        @(negedge clk);
        check("t5_vid5", w_t'(vm_tvalid), w_t'(4'b0010));
        check("t5_vid5_d", vm_tdata, vframe(16'h0081, 12'h005, 8'h51));
        v_tdata = vframe(16'h0088, 12'h005, 8'h52);
        @(negedge clk);
        check("t5_bad_tpid_v", w_t'(vm_tvalid), w_t'(4'b0000));
        check("t5_bad_tpid_drop", w_t'(v_drop), w_t'(32'd1));
        v_en = 4'b1101; v_tdata = vframe(16'h0081, 12'h005, 8'h53);
        @(negedge clk);
        check("t5_disabled_v", w_t'(vm_tvalid), w_t'(4'b0000));
        check("t5_disabled_drop", w_t'(v_drop), w_t'(32'd2));
        v_en = 4'b1111; v_tdata = vframe(16'h0081, 12'h30C, 8'h54);
        @(negedge clk);
        check("t5_vid30c", w_t'(vm_tvalid), w_t'(4'b1000));
        v_tvalid = 1'b0; v_tlast = 1'b0;
        @(negedge clk);
        check("t5_fwd1", w_t'(v_fwd[1*32 +: 32]), w_t'(32'd1));
        check("t5_fwd3", w_t'(v_fwd[3*32 +: 32]), w_t'(32'd1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/input_p4_demux.md
Name: input_p4_demux

Overview:
- Parametrised AXI4-Stream 1-to-NUM_VS packet demultiplexer.
- Sits between the input arbiter and the NUM_VS virtual P4 switch instances.
- Classifies each packet on its first beat, by destination MAC or by 802.1Q VLAN ID, against a run-time match table.
- Streams the whole packet to the selected instance with full tready backpressure. Unmatched packets are discarded and counted.

Parameters:
- C_AXIS_DATA_WIDTH, 256, tdata width in bits; minimum 128.
- C_AXIS_TUSER_WIDTH, 128, tuser width in bits; passed through unchanged.
- NUM_VS, 4, number of output channels; range 1..8.
- SEL_MODE, 0, classification key: 0 = dst MAC (48 b), 1 = VLAN ID (12 b).
- KEY_W, 48, width of each match-table entry; only the low 12 bits are used when SEL_MODE=1.

Ports:
- axis_aclk  in  1  clock.
- axis_resetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  input beat data.
- s_axis_tkeep  in  C_AXIS_DATA_WIDTH/8  input byte enables.
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  input sideband.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tlast  in  1  last beat of input packet.
- s_axis_tready  out  1  input beat accepted this cycle.
- m_axis_tdata  out  C_AXIS_DATA_WIDTH  shared output data, meaningful only on the asserted channel.
- m_axis_tkeep  out  C_AXIS_DATA_WIDTH/8  shared output byte enables.
- m_axis_tuser  out  C_AXIS_TUSER_WIDTH  shared output sideband.
- m_axis_tlast  out  1  shared output last.
- m_axis_tvalid  out  NUM_VS  per-channel valid; at most one bit set.
- m_axis_tready  in  NUM_VS  per-channel ready.
- match_table  in  NUM_VS*KEY_W  entry k sits at [k*KEY_W +: KEY_W]; quasi-static.
- chan_enable  in  NUM_VS  a disabled channel never matches.
- drop_cnt  out  32  saturating count of dropped packets.
- fwd_cnt  out  NUM_VS*32  per-channel count of forwarded packets (counted on the output tlast handshake); wraps.

Behaviour:
- Key extraction, first beat only:
  - MAC key = tdata[47:0].
  - VLAN mode: TPID = tdata[111:96], must equal 16'h0081; VLAN ID = {tdata[115:112], tdata[127:120]}.
  - VLAN mode with wrong TPID: no match.
- Match:
  - Channel k matches when chan_enable[k] is set and its key equals entry k (low 12 bits in VLAN mode).
  - Several matches: lowest k wins.
- States: IDLE, FWD, DROP.
  - IDLE: on an accepted beat, a match loads sel and the output register, and goes to FWD; no match goes to DROP. If that beat has tlast, stay IDLE. The drop_cnt increment happens on tlast.
  - FWD: each accepted beat loads the output register. Accepted tlast returns to IDLE.
  - DROP: s_axis_tready=1 and beats are discarded. Accepted tlast increments drop_cnt and returns to IDLE.
- Output register: single stage, holding data, keep, user, last and valid.
  - m_axis_tvalid[k] = out_valid && (sel==k).
  - Output clears when m_axis_tready[sel] is high and no new beat loads.
- Ready:
  - IDLE/FWD: s_axis_tready = !out_valid || m_axis_tready[sel].
  - DROP: s_axis_tready = 1.
- Latency and throughput: an accepted beat appears on the output 1 cycle later; 1 beat/clk with no bubbles across packet boundaries.
- A new packet's first beat may load in the same cycle the previous packet's last beat drains. sel updates in that same cycle.
- tkeep and tuser are passed through unmodified. No re-alignment.
- Output stays stable while m_axis_tvalid is set and ready is low (AXI-S rule).
- match_table and chan_enable are sampled only on the first beat; changes mid-packet have no effect.
- Reset, asynchronous, any time including mid-packet:
  - State IDLE; sel=0; out_valid=0.
  - All m_axis outputs 0; s_axis_tready=0.
  - Counters 0.
  - s_axis_tready rises the first clock after deassertion. A partial packet is lost.
- drop_cnt saturates at 32'hFFFFFFFF. fwd_cnt wraps.

Decomposition:
- Package input_p4_demux_pkg holds:
  - state encoding (IDLE=0, FWD=1, DROP=2);
  - MAC_LO=0, VLAN_TPID_LO=96, VLAN_TPID=16'h0081;
  - SEL_MAC=0, SEL_VLAN=1.
- One sub-module, input_p4_classifier: combinational key extraction plus priority match. Inputs tdata, match_table, chan_enable. Outputs hit and idx ($clog2(NUM_VS) bits, min 1).

Test Plan:
1. MAC mode, table {110100000008, 220200000008, 330300000008, 440400000008}, 3-beat pkt to 330300000008, all ready -> m_axis_tvalid=4'b0100 for 3 consecutive cycles starting 1 clk after the first accept; tlast on beat 3; fwd_cnt[2]=1.
2. Back-to-back 1-beat pkts to ch0 then ch3 -> tvalid 0001 then 1000 on consecutive cycles; s_axis_tready stays 1.
3. Unknown dst MAC 5-beat pkt -> no m tvalid; tready=1 throughout; drop_cnt=1. Following matched pkt forwards normally.
4. Backpressure: m_axis_tready[1] low 4 cycles mid-pkt -> s_axis_tready low; output data held stable; no beat lost or duplicated.
5. SEL_MODE=1, table entry1=12'h005, TPID 0081 with VLAN ID 5 -> ch1. Same frame with TPID 0088 -> dropped. chan_enable[1]=0 -> dropped.
6. Assert axis_resetn low mid-packet -> all outputs 0 immediately. After release a fresh pkt forwards correctly and counters restart at 0.
